// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
package rv32_fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DISCARD,
    S_HALT
  } state_e;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [3:0] MCAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] MCAUSE_INSTR_FAULT      = 4'd1;

  // Contents of the decode-facing output register.
  typedef struct packed {
    logic        valid;
    logic        exception;
    logic [3:0]  cause;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] next_pc;
  } slot_t;

  // Exception slots carry a NOP and never a prediction.
  function automatic slot_t exception_slot(input logic [31:0] pc,
                                           input logic [3:0]  cause,
                                           input logic [31:0] nop);
    return '{valid: 1'b1, exception: 1'b1, cause: cause, taken: 1'b0,
             pc: pc, instr: nop, next_pc: pc + 32'd4};
  endfunction

endpackage

// File: rtl/rv32_fetch_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
interface rv32_fetch_if;

  logic        instr_read_out;
  logic [31:0] instr_address_out;
  logic        instr_ready_in;
  logic [31:0] instr_read_value_in;
  logic        instr_fault_in;

  modport master (
    output instr_read_out,
    output instr_address_out,
    input  instr_ready_in,
    input  instr_read_value_in,
    input  instr_fault_in
  );

  modport slave (
    input  instr_read_out,
    input  instr_address_out,
    output instr_ready_in,
    output instr_read_value_in,
    output instr_fault_in
  );

endinterface

// File: rtl/rv32_fetch_predict.sv
// Static branch predictor: JAL and backward conditional branches are taken.
module rv32_fetch_predict
  import rv32_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        taken,
  output logic [31:0] next_pc
);

  logic [31:0] imm_j;
  logic [31:0] imm_b;

  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    taken   = 1'b0;
    next_pc = pc + 32'd4;
    if (instr[6:0] == OPCODE_JAL) begin
      taken   = 1'b1;
      next_pc = pc + imm_j;
    end else if (instr[6:0] == OPCODE_BRANCH && instr[31]) begin
      taken   = 1'b1;
      next_pc = pc + imm_b;
    end
  end

endmodule

// File: rtl/rv32_fetch.sv
// RV32 fetch stage: PC register, instruction bus master, one-entry holding
// buffer, stale-response discard and a registered slot into decode.
module rv32_fetch
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         stall_in,
  input  logic         redirect_in,
  input  logic [31:0]  redirect_pc_in,
  rv32_fetch_if.master bus,
  output logic         valid_out,
  output logic         exception_out,
  output logic [3:0]   exception_cause_out,
  output logic         branch_predicted_taken_out,
  output logic [31:0]  pc_out,
  output logic [31:0]  instr_out,
  output logic [31:0]  next_pc_out
);

  state_e      state;
  logic        running;
  logic [31:0] fetch_pc;
  logic [31:0] saved_pc;
  logic        buf_valid;
  logic        buf_fault;
  logic [31:0] buf_instr;
  slot_t       slot;

  logic        misaligned;
  logic        read;
  logic        complete;
  logic [31:0] pred_instr;
  logic        pred_taken;
  logic [31:0] pred_next;
  slot_t       slot_normal;
  slot_t       slot_fault;
  slot_t       slot_misaligned;

  // running keeps the bus idle until the first edge after reset release.
  assign misaligned = fetch_pc[1:0] != 2'b00;
  assign read       = running && ((state == S_FETCH && !misaligned) || state == S_DISCARD);
  assign complete   = read && bus.instr_ready_in;
  assign pred_instr = (state == S_HOLD) ? buf_instr : bus.instr_read_value_in;

  assign bus.instr_read_out    = read;
  assign bus.instr_address_out = {fetch_pc[31:2], 2'b00};

  rv32_fetch_predict u_predict (
    .pc      (fetch_pc),
    .instr   (pred_instr),
    .taken   (pred_taken),
    .next_pc (pred_next)
  );

  assign slot_normal = '{valid: 1'b1, exception: 1'b0, cause: MCAUSE_INSTR_MISALIGNED,
                         taken: pred_taken, pc: fetch_pc, instr: pred_instr,
                         next_pc: pred_next};
  assign slot_fault      = exception_slot(fetch_pc, MCAUSE_INSTR_FAULT, NOP_INSTR);
  assign slot_misaligned = exception_slot(fetch_pc, MCAUSE_INSTR_MISALIGNED, NOP_INSTR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      running   <= 1'b0;
      fetch_pc  <= RESET_PC;
      saved_pc  <= '0;
      buf_valid <= 1'b0;
      buf_fault <= 1'b0;
      buf_instr <= '0;
      slot      <= '0;
    end else begin
      running <= 1'b1;
      if (redirect_in) begin
        slot.valid     <= 1'b0;
        slot.exception <= 1'b0;
        slot.taken     <= 1'b0;
        buf_valid      <= 1'b0;
        // An outstanding read must finish at its own address before refetching.
        if (read && !bus.instr_ready_in) begin
          saved_pc <= redirect_pc_in;
          state    <= S_DISCARD;
        end else begin
          fetch_pc <= redirect_pc_in;
          state    <= S_FETCH;
        end
      end else begin
        // NOTE: non-blocking assignments; a later emit below overrides this bubble.
        if (!stall_in) begin
          slot.valid     <= 1'b0;
          slot.exception <= 1'b0;
        end
        unique case (state)
          S_FETCH: begin
            if (complete) begin
              if (stall_in) begin
                buf_valid <= 1'b1;
                buf_fault <= bus.instr_fault_in;
                buf_instr <= bus.instr_read_value_in;
                state     <= S_HOLD;
              end else if (bus.instr_fault_in) begin
                slot  <= slot_fault;
                state <= S_HALT;
              end else begin
                slot     <= slot_normal;
                fetch_pc <= pred_next;
              end
            end else if (running && misaligned && !stall_in) begin
              slot  <= slot_misaligned;
              state <= S_HALT;
            end
          end
          S_HOLD: begin
            if (!stall_in && buf_valid) begin
              buf_valid <= 1'b0;
              if (buf_fault) begin
                slot  <= slot_fault;
                state <= S_HALT;
              end else begin
                slot     <= slot_normal;
                fetch_pc <= pred_next;
                state    <= S_FETCH;
              end
            end
          end
          S_DISCARD: begin
            if (complete) begin
              fetch_pc <= saved_pc;
              state    <= S_FETCH;
            end
          end
          S_HALT: begin
          end
          default: state <= S_HALT;
        endcase
      end
    end
  end

  assign valid_out                  = slot.valid;
  assign exception_out              = slot.exception;
  assign exception_cause_out        = slot.cause;
  assign branch_predicted_taken_out = slot.taken;
  assign pc_out                     = slot.pc;
  assign instr_out                  = slot.instr;
  assign next_pc_out                = slot.next_pc;

endmodule
